fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage RISC-V core. It sits directly upstream of the hazard unit. It consumes StallF, StallD and FlushD from the hazard unit, and PCSrcE/PCTargetE from Execute. It produces PCD, PCPlus4D and InstrD, whose Rs1D/Rs2D fields feed the hazard unit. It drives a request/grant/response instruction-memory port with one outstanding request and a one-entry holding buffer, so memory wait states become bubbles instead of lost instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, InstrD value on bubble/flush (addi x0,x0,0)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- StallF  in  1  hazard unit: do not issue new fetch
- StallD  in  1  hazard unit: hold IF/ID register
- FlushD  in  1  hazard unit: bubble IF/ID (priority over StallD)
- PCSrcE  in  1  taken branch/jump redirect
- PCTargetE  in  32  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (PCF)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response for the outstanding request
- imem_rdata  in  32  instruction word
- PCF  out  32  next address to fetch
- PCD, PCPlus4D  out  32  PC and PC+4 of InstrD
- InstrD  out  32  decoded-stage instruction
- ValidD  out  1  InstrD is a real instruction

## Operation
- Fetch FSM states: IDLE (nothing outstanding), BUSY (one outstanding, response kept), DRAIN (one outstanding, response discarded).
- Issue condition: state IDLE, or state BUSY with imem_rvalid; and !StallF, !PCSrcE, !buf_valid, !(imem_rvalid & StallD & state==BUSY).
- imem_req = issue condition; imem_addr = PCF.
- On req & gnt: pc_inflight <= PCF; PCF <= PCF + 4 (mod 2^32); state -> BUSY.
- On rvalid in BUSY with no new grant: state -> IDLE. On rvalid in DRAIN: data dropped, state -> IDLE.
- Response routing in BUSY: if IF/ID loads this cycle and buf empty, go straight to IF/ID. Otherwise write {imem_rdata, pc_inflight} to holding buffer (buf_valid <= 1).
- IF/ID register, evaluated in order:
  - FlushD: ValidD <= 0, InstrD <= NOP_INSTR.
  - else StallD: hold.
  - else buf_valid: load buffer, clear buf_valid.
  - else kept response: load it.
  - else bubble.
  - PCPlus4D = loaded PC + 4.
- Redirect (PCSrcE=1), overrides StallF/StallD:
  - PCF <= PCTargetE.
  - buf_valid <= 0.
  - BUSY -> DRAIN; a response arriving the same cycle is dropped.
  - No issue that cycle.
  - Hazard unit asserts FlushD simultaneously.
- Misaligned PCTargetE[1:0] is passed unchanged; trap handling is not in scope.

## Timing
- Reset (async, rst_n=0):
  - PCF=RESET_PC; state IDLE; buf_valid=0; imem_req=0 while in reset.
  - ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
- First request is issued in the first cycle after rst_n deasserts.
- Zero-wait memory (gnt same cycle, rvalid next cycle):
  - Request at PC in cycle n -> InstrD valid at edge ending cycle n+1.
  - Sustained 1 instruction/cycle.
- Redirect in cycle n: request to PCTargetE in cycle n+1. First target instruction reaches ValidD no earlier than end of cycle n+2. A DRAIN response delays it until that response returns.
- Reset asserted mid-request discards the outstanding response. The memory must not return it after reset.
- Buffer never overflows; the issue condition guarantees at most one response pending with buf full.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds 32-bit wrapping outputs perf_fetched (kept responses), perf_bubbles (IF/ID loads with ValidD=0, flushes excluded) and perf_drained (discarded responses).
  - All reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package riscv_pkg: NOP_INSTR, RESET_PC default, fetch-state enum {IDLE, BUSY, DRAIN}.
- One sub-module: if_id_reg (IF/ID register with stall, flush and bubble insertion, reset values above). FSM, PC and buffer stay in fetch_stage.

## Test plan
- Reset release, zero-wait memory returning addr as data -> InstrD sequence 0,4,8,... on consecutive cycles, PCPlus4D=PCD+4.
- gnt held low 3 cycles -> imem_req stays high with imem_addr constant; 3 extra ValidD=0 bubbles; no instruction skipped.
- StallD high 2 cycles while response arrives -> response lands in buffer, no issue while full; after release InstrD = buffered word with correct PCD.
- PCSrcE=1, PCTargetE=0x100 while BUSY, response delayed 2 cycles -> stale word dropped (perf_drained=1); next ValidD instruction has PCD=0x100.
- FlushD and StallD together -> ValidD=0, InstrD=0x00000013.
- rst_n pulsed low mid-BUSY -> PCF=RESET_PC, ValidD=0 immediately, state IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared fetch-stage constants, fetch-state encoding, IF/ID entry
// Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_BUSY  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with flush, stall and bubble insertion
// Revision  : 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         stall_i,
  input  logic         load_valid_i,
  input  fetch_entry_t load_entry_i,
  output logic         valid_o,
  output logic [31:0]  instr_o,
  output logic [31:0]  pc_o,
  output logic [31:0]  pc_plus4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;

  // Flush beats stall; bubbles leave the PC fields untouched.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall_i) begin
      if (load_valid_i) begin
        valid_d = 1'b1;
        instr_d = load_entry_i.instr;
        pc_d    = load_entry_i.pc;
        pc4_d   = pc_plus4(load_entry_i.pc);
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : instruction fetch with req/gnt/rvalid port, one-entry holding
//               buffer and IF/ID register. Optional: FETCH_PERF_CNT_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] InstrD,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_drained
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  inflight_q, inflight_d;
  fetch_entry_t buf_q, buf_d;
  logic         buf_valid_q, buf_valid_d;

  logic         w_rsp_busy, w_issue, w_grant, w_keep, w_drop;
  logic         w_advance, w_direct, w_load_valid;
  fetch_entry_t w_rsp_entry, w_load_entry;

  assign w_rsp_busy = (state_q == FS_BUSY) && imem_rvalid;

  // A stalled IF/ID receiving a response would fill the buffer, so no new issue.
  assign w_issue = ((state_q == FS_IDLE) || w_rsp_busy) && !StallF && !PCSrcE &&
                   !buf_valid_q && !(w_rsp_busy && StallD);

  assign imem_req  = rst_n && w_issue;
  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;
  assign w_grant   = imem_req && imem_gnt;

  assign w_keep    = w_rsp_busy && !PCSrcE;
  assign w_drop    = imem_rvalid && ((state_q == FS_DRAIN) ||
                                     ((state_q == FS_BUSY) && PCSrcE));
  assign w_advance = !FlushD && !StallD;
  assign w_direct  = w_keep && w_advance && !buf_valid_q;

  assign w_rsp_entry.instr = imem_rdata;
  assign w_rsp_entry.pc    = inflight_q;
  assign w_load_valid      = buf_valid_q || w_keep;
  assign w_load_entry      = buf_valid_q ? buf_q : w_rsp_entry;

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    inflight_d  = inflight_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;

    if (w_advance && buf_valid_q) buf_valid_d = 1'b0;
    if (w_keep && !w_direct) begin
      buf_d       = w_rsp_entry;
      buf_valid_d = 1'b1;
    end

    if (PCSrcE) begin
      pcf_d       = PCTargetE;
      buf_valid_d = 1'b0;
      // Same-cycle response is dropped; only a still-pending one needs draining.
      if (state_q == FS_BUSY) state_d = imem_rvalid ? FS_IDLE : FS_DRAIN;
      else if ((state_q == FS_DRAIN) && imem_rvalid) state_d = FS_IDLE;
    end else begin
      if (imem_rvalid && (state_q != FS_IDLE)) state_d = FS_IDLE;
      if (w_grant) begin
        inflight_d = pcf_q;
        pcf_d      = pcf_q + 32'd4;
        state_d    = FS_BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_IDLE;
      pcf_q       <= RESET_PC;
      inflight_q  <= 32'd0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      inflight_q  <= inflight_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (FlushD),
    .stall_i      (StallD),
    .load_valid_i (w_load_valid),
    .load_entry_i (w_load_entry),
    .valid_o      (ValidD),
    .instr_o      (InstrD),
    .pc_o         (PCD),
    .pc_plus4_o   (PCPlus4D)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q, perf_drained_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
      perf_drained_q <= 32'd0;
    end else begin
      if (w_keep)                       perf_fetched_q <= perf_fetched_q + 32'd1;
      if (w_advance && !w_load_valid)   perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (w_drop)                       perf_drained_q <= perf_drained_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
  assign perf_drained = perf_drained_q;
`endif

endmodule

`default_nettype wire
